// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// grouped pipeline-register controls with their canonical settings.
package hazard_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } hazState_t;

  // Bit order matches the {we x5, flush x4} view used by the top level.
  typedef struct packed {
    logic pcWe;
    logic ifidWe;
    logic idexWe;
    logic exmemWe;
    logic memwbWe;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
    logic memwbFlush;
  } pipeCtrl_t;

  function automatic pipeCtrl_t mkCtrl(input logic [4:0] we, input logic [3:0] flush);
    return pipeCtrl_t'({we, flush});
  endfunction

  localparam pipeCtrl_t CTRL_BOOT    = pipeCtrl_t'(9'b00000_1111);
  localparam pipeCtrl_t CTRL_FREEZE  = pipeCtrl_t'(9'b00000_0001);
  localparam pipeCtrl_t CTRL_HALT    = pipeCtrl_t'(9'b00000_0000);
  localparam pipeCtrl_t CTRL_BRANCH  = pipeCtrl_t'(9'b11111_1100);
  localparam pipeCtrl_t CTRL_LOADUSE = pipeCtrl_t'(9'b00111_0100);
  localparam pipeCtrl_t CTRL_ADVANCE = pipeCtrl_t'(9'b11111_0000);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register: clear wins, then increment unless already all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core: boot hold, load-use
// bubbles, branch squashes, memory wait freeze with watchdog, perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RegWEn,
  input  logic             ex_MemRead,
  input  logic             ex_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  hazState_t         state, nextState;
  logic [BOOT_W-1:0] bootCnt, bootNext;
  logic [WAIT_W-1:0] waitCnt, waitNext;
  pipeCtrl_t         ctrl, runCtrl;
  logic              memStall, loadUse, branchActed, active;

  assign memStall = dmem_req && !dmem_ready;

  // Non-frozen RUN decision; a taken branch squashes the ID instruction so load-use is moot.
  always_comb begin
    loadUse = ex_MemRead && ex_RegWEn && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    if (ex_br_taken) begin
      runCtrl = CTRL_BRANCH;
    end else if (loadUse) begin
      runCtrl = CTRL_LOADUSE;
    end else begin
      runCtrl = CTRL_ADVANCE;
    end
  end

  // FSM next state, boot/wait counters and pipeline controls.
  always_comb begin
    ctrl        = CTRL_BOOT;
    nextState   = state;
    bootNext    = bootCnt;
    waitNext    = waitCnt;
    branchActed = 1'b0;
    case (state)
      BOOT: begin
        if (bootCnt == BOOT_W'(BOOT_CYCLES - 1)) begin
          nextState = RUN;
          bootNext  = {BOOT_W{1'b0}};
        end else begin
          bootNext  = bootCnt + BOOT_W'(1);
        end
      end
      RUN: begin
        if (memStall) begin
          ctrl      = CTRL_FREEZE;
          nextState = MEM_WAIT;
          waitNext  = WAIT_W'(1);
        end else begin
          ctrl        = runCtrl;
          branchActed = ex_br_taken;
        end
      end
      MEM_WAIT: begin
        // A ready arriving on the timeout cycle still releases the freeze.
        if (dmem_ready) begin
          ctrl        = runCtrl;
          branchActed = ex_br_taken;
          nextState   = RUN;
          waitNext    = {WAIT_W{1'b0}};
        end else begin
          ctrl = CTRL_FREEZE;
          if (waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            nextState = HALT;
          end else begin
            waitNext  = waitCnt + WAIT_W'(1);
          end
        end
      end
      HALT: begin
        ctrl = CTRL_HALT;
      end
      default: begin
        ctrl      = CTRL_BOOT;
        nextState = BOOT;
      end
    endcase
  end

  // State and sequencing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      bootCnt <= {BOOT_W{1'b0}};
      waitCnt <= {WAIT_W{1'b0}};
    end else begin
      state   <= nextState;
      bootCnt <= bootNext;
      waitCnt <= waitNext;
    end
  end

  // Sticky error flag, trailing the HALT state by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else begin
      halted <= (state == HALT);
    end
  end

  assign active = (state == RUN) || (state == MEM_WAIT);

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (perf_clr),
    .inc  (active && !ctrl.pcWe),
    .cnt  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (perf_clr),
    .inc  (active && branchActed),
    .cnt  (flush_cnt)
  );

  assign pc_we       = ctrl.pcWe;
  assign ifid_we     = ctrl.ifidWe;
  assign idex_we     = ctrl.idexWe;
  assign exmem_we    = ctrl.exmemWe;
  assign memwb_we    = ctrl.memwbWe;
  assign ifid_flush  = ctrl.ifidFlush;
  assign idex_flush  = ctrl.idexFlush;
  assign exmem_flush = ctrl.exmemFlush;
  assign memwb_flush = ctrl.memwbFlush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the control rules.
module tb_hazard_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;
  localparam logic [8:0] V_BOOT = 9'b00000_1111, V_FRZ = 9'b00000_0001, V_HALT = 9'b0,
                         V_BR = 9'b11111_1100, V_ADV = 9'b11111_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_RegWEn, ex_MemRead, ex_br_taken;
  logic dmem_req, dmem_ready, perf_clr;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] obs;

  int errors = 0, checks = 0;
  // model: mode 0 boot, 1 run, 2 waiting on memory, 3 halted
  int mMode, bootSeen, freezeRun, stallM, flushM;
  bit haltM;

  assign obs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};

  hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_RegWEn(ex_RegWEn), .ex_MemRead(ex_MemRead), .ex_br_taken(ex_br_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  function automatic bit frozenNow();
    if (mMode == 1) return dmem_req && !dmem_ready;
    if (mMode == 2) return !dmem_ready;
    return 1'b0;
  endfunction

  function automatic logic [8:0] expCtrl();
    bit dep;
    dep = ex_MemRead && ex_RegWEn && (ex_rd != 0) &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (mMode == 0) return V_BOOT;
    if (mMode == 3) return V_HALT;
    if (frozenNow()) return V_FRZ;
    if (ex_br_taken) return V_BR;
    if (dep) return 9'b00111_0100;
    return V_ADV;
  endfunction

  task automatic modelInit();
    mMode = 0; bootSeen = 0; freezeRun = 0; stallM = 0; flushM = 0; haltM = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    logic [8:0] e;
    bit frz, wasHalt;
    if (!rst_n) begin
      modelInit();
    end else begin
      e = expCtrl(); frz = frozenNow(); wasHalt = (mMode == 3);
      if (perf_clr) begin
        stallM = 0; flushM = 0;
      end else if (mMode == 1 || mMode == 2) begin
        if (!e[8] && stallM < CMAX) stallM++;
        if (!frz && ex_br_taken && flushM < CMAX) flushM++;
      end
      case (mMode)
        0: begin bootSeen++; if (bootSeen == BOOT_CYCLES) mMode = 1; end
        1: if (frz) begin mMode = 2; freezeRun = 1; end
        2: if (frz) begin freezeRun++; if (freezeRun == MEM_TIMEOUT) mMode = 3; end
           else mMode = 1;
        default: ;
      endcase
      haltM = wasHalt;
    end
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_RegWEn = 0;
    ex_MemRead = 0; ex_br_taken = 0; dmem_req = 0; dmem_ready = 0; perf_clr = 0;
  endtask

  task automatic setLoadUse();
    ex_MemRead = 1; ex_RegWEn = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 9; id_use_rs1 = 1;
  endtask

  task automatic reset_dut();
    clearIn(); rst_n = 0; modelInit();
    @(posedge clk); #1; rst_n = 1;
    repeat (BOOT_CYCLES) cycle();
  endtask

  task automatic test_reset();
    clearIn(); rst_n = 0; modelInit(); #1;
    checks++; if (obs !== V_BOOT) begin errors++; $display("FAIL rst_ctrl: got %b want %b", obs, V_BOOT); end
    checks++; if (halted !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin errors++;
      $display("FAIL rst_regs: got h=%b s=%0d f=%0d want 0", halted, stall_cnt, flush_cnt); end
    @(posedge clk); #1; rst_n = 1;
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      #1; checks++; if (obs !== V_BOOT) begin errors++; $display("FAIL boot%0d: got %b want %b", i, obs, V_BOOT); end
      cycle();
    end
    #1; checks++; if (obs !== V_ADV) begin errors++; $display("FAIL boot_run: got %b want %b", obs, V_ADV); end
    checks++; if (halted !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin errors++;
      $display("FAIL boot_regs: got h=%b s=%0d f=%0d want 0", halted, stall_cnt, flush_cnt); end
  endtask

  task automatic test_load_use();
    setLoadUse(); #1;
    checks++; if ({pc_we, ifid_we, idex_flush, exmem_we, memwb_we} !== 5'b00111) begin errors++;
      $display("FAIL lu_ctrl: got %b want 00111", {pc_we, ifid_we, idex_flush, exmem_we, memwb_we}); end
    cycle(); clearIn(); #1;
    checks++; if (obs !== V_ADV) begin errors++; $display("FAIL lu_release: got %b want %b", obs, V_ADV); end
    checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL lu_stall: got %0d want 1", stall_cnt); end
    ex_rd = 0; ex_MemRead = 1; ex_RegWEn = 1; id_rs1 = 0; id_use_rs1 = 1; #1;
    checks++; if (obs !== V_ADV) begin errors++; $display("FAIL lu_x0: got %b want %b", obs, V_ADV); end
    cycle(); clearIn();
  endtask

  task automatic test_branch_load_use();
    perf_clr = 1; cycle(); perf_clr = 0;
    setLoadUse(); ex_br_taken = 1; #1;
    checks++; if ({ifid_flush, idex_flush, pc_we} !== 3'b111) begin errors++;
      $display("FAIL br_ctrl: got %b want 111", {ifid_flush, idex_flush, pc_we}); end
    cycle(); clearIn(); #1;
    checks++; if (flush_cnt !== 8'd1 || stall_cnt !== 8'd0) begin errors++;
      $display("FAIL br_cnt: got f=%0d s=%0d want f=1 s=0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_mem_wait();
    dmem_req = 1; dmem_ready = 1; #1;
    checks++; if (obs !== V_ADV) begin errors++; $display("FAIL mem_sameready: got %b want %b", obs, V_ADV); end
    cycle(); perf_clr = 1; dmem_req = 0; cycle(); perf_clr = 0;
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1; checks++; if (obs !== V_FRZ) begin errors++; $display("FAIL mem_frz%0d: got %b want %b", i, obs, V_FRZ); end
      cycle();
    end
    dmem_ready = 1; ex_br_taken = 1; #1;
    checks++; if (obs !== V_BR) begin errors++; $display("FAIL mem_release: got %b want %b", obs, V_BR); end
    cycle(); clearIn(); #1;
    checks++; if (stall_cnt !== 8'd3 || flush_cnt !== 8'd1) begin errors++;
      $display("FAIL mem_cnt: got s=%0d f=%0d want s=3 f=1", stall_cnt, flush_cnt); end
  endtask

  task automatic test_timeout();
    reset_dut(); dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1; checks++; if (obs !== V_FRZ || halted !== 1'b0) begin errors++;
        $display("FAIL to_frz%0d: got %b h=%b want %b h=0", i, obs, halted, V_FRZ); end
      cycle();
    end
    #1; checks++; if (obs !== V_HALT || halted !== 1'b0) begin errors++;
      $display("FAIL to_enter: got %b h=%b want %b h=0", obs, halted, V_HALT); end
    cycle();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = 1'($urandom); ex_br_taken = 1'($urandom); dmem_req = 1'($urandom); #1;
      checks++; if (obs !== V_HALT || halted !== 1'b1) begin errors++;
        $display("FAIL to_hold%0d: got %b h=%b want %b h=1", i, obs, halted, V_HALT); end
      cycle();
    end
    rst_n = 0; modelInit(); #1;
    checks++; if (obs !== V_BOOT || halted !== 1'b0) begin errors++;
      $display("FAIL to_asyncrst: got %b h=%b want %b h=0", obs, halted, V_BOOT); end
    reset_dut(); dmem_req = 1; dmem_ready = 0;
    repeat (MEM_TIMEOUT - 1) cycle();
    dmem_ready = 1; #1;
    checks++; if (obs !== V_ADV) begin errors++; $display("FAIL to_lastready: got %b want %b", obs, V_ADV); end
    cycle(); clearIn(); cycle(); #1;
    checks++; if (obs !== V_ADV || halted !== 1'b0) begin errors++;
      $display("FAIL to_nohalt: got %b h=%b want %b h=0", obs, halted, V_ADV); end
  endtask

  task automatic test_saturation();
    perf_clr = 1; cycle(); perf_clr = 0; setLoadUse();
    repeat (CMAX + 5) cycle();
    checks++; if (stall_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %0h want ff", stall_cnt); end
    perf_clr = 1; cycle(); perf_clr = 0; clearIn(); #1;
    checks++; if (stall_cnt !== 8'h00) begin errors++; $display("FAIL sat_clr: got %0h want 0", stall_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0; modelInit(); #1;
        checks++; if (obs !== V_BOOT || halted !== 1'b0 || stall_cnt !== 0) begin errors++;
          $display("FAIL rnd_rst%0d: got %b h=%b s=%0d", n, obs, halted, stall_cnt); end
        @(posedge clk); #1; rst_n = 1;
      end
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); ex_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); ex_RegWEn = 1'($urandom);
      ex_MemRead = 1'($urandom); ex_br_taken = ($urandom_range(0, 3) == 0);
      dmem_req = ($urandom_range(0, 2) == 0); dmem_ready = 1'($urandom);
      perf_clr = ($urandom_range(0, 63) == 0); #1;
      checks++; if (obs !== expCtrl()) begin errors++; $display("FAIL rnd_ctrl%0d: got %b want %b", n, obs, expCtrl()); end
      checks++; if (halted !== haltM) begin errors++; $display("FAIL rnd_halt%0d: got %b want %b", n, halted, haltM); end
      checks++; if (stall_cnt !== 8'(stallM)) begin errors++; $display("FAIL rnd_stall%0d: got %0d want %0d", n, stall_cnt, stallM); end
      checks++; if (flush_cnt !== 8'(flushM)) begin errors++; $display("FAIL rnd_flush%0d: got %0d want %0d", n, flush_cnt, flushM); end
      cycle();
    end
  endtask

  initial begin
    clearIn(); modelInit();
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_saturation();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
